// File: rtl/alu_pipe.sv
// alu_pipe: pipelined RV64I/RV32I integer ALU with valid/ready handshakes.
//
// Executes OP, OP-IMM, OP-32, OP-IMM-32, LUI and AUIPC. The input side
// registers the raw operands into stage 0. Stage 0 computes the result
// combinationally from those registers. Stages 1..STAGES-1 only carry the
// result, the scoreboard ID and rd toward the output.
//
// Parameters:
//   XLEN   - datapath width, 32 or 64
//   SID_W  - scoreboard ID width
//   STAGES - number of register stages, 1..4 (accept-to-result latency)
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush_i      - kill every in-flight op and discard this cycle's accept
//   in_valid_i   - op offered;   in_ready_o - op accepted this cycle
//   in_sid_i     - scoreboard ID; in_inst_i - raw instruction
//   in_pc_i      - instruction PC; in_rs1_i/in_rs2_i - register operands
//   out_valid_o  - result available; out_ready_i - consumer takes result
//   out_sid_o    - scoreboard ID; out_rd_o - inst[11:7]; out_value_o - result
//   busy_o       - any stage holds a valid op
module alu_pipe #(
  parameter int XLEN   = 64,
  parameter int SID_W  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SID_W-1:0] in_sid_i,
  input  logic [31:0]      in_inst_i,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [XLEN-1:0]  in_rs1_i,
  input  logic [XLEN-1:0]  in_rs2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SID_W-1:0] out_sid_o,
  output logic [4:0]       out_rd_o,
  output logic [XLEN-1:0]  out_value_o,
  output logic             busy_o
);

  localparam int LAST = STAGES - 1;

  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_adv;
  logic              w_accept;

  logic [31:0]       r_inst;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic [SID_W-1:0]  r_sid0;

  logic [XLEN-1:0]   w_stVal [STAGES];
  logic [SID_W-1:0]  w_stSid [STAGES];
  logic [4:0]        w_stRd  [STAGES];

  // Stage k advances if it or any stage after it is empty, or the consumer
  // takes the result. Expressed as a running OR from the output end so the
  // chain has no self-referencing vector.
  always_comb begin
    logic v_acc;
    v_acc = out_ready_i;
    w_adv = '0;
    for (int k = LAST; k >= 0; k--) begin
      v_acc    = v_acc | ~r_valid[k];
      w_adv[k] = v_acc;
    end
  end

  assign in_ready_o = ~r_valid[0] | w_adv[0];
  assign w_accept   = in_valid_i & in_ready_o & ~flush_i;
  assign busy_o     = |r_valid;

  // Valid bits: flush wins over any movement; bubbles collapse because an
  // empty stage always advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else begin
      if (w_adv[0]) r_valid[0] <= in_valid_i;
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) r_valid[k] <= r_valid[k-1];
      end
    end
  end

  // Stage 0 captures the raw operands; compute happens from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst <= '0;
      r_pc   <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_sid0 <= '0;
    end else if (w_accept) begin
      r_inst <= in_inst_i;
      r_pc   <= in_pc_i;
      r_rs1  <= in_rs1_i;
      r_rs2  <= in_rs2_i;
      r_sid0 <= in_sid_i;
    end
  end

  // ---------------------------------------------------------------------
  // Decode and execute
  // ---------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic            w_isOp, w_isOpImm, w_isOp32, w_isOpImm32, w_isLui, w_isAuipc;
  logic            w_isSub, w_isSra;
  logic [XLEN-1:0] w_immI, w_immU, w_opB;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_full;
  logic [31:0]     w_a32, w_b32, w_w32;
  logic [4:0]      w_sh5;
  logic [XLEN-1:0] w_wide;
  logic [XLEN-1:0] w_result;

  assign w_opcode    = r_inst[6:0];
  assign w_f3        = r_inst[14:12];
  assign w_isOp      = (w_opcode == OPC_OP);
  assign w_isOpImm   = (w_opcode == OPC_OPIMM);
  assign w_isOp32    = (w_opcode == OPC_OP32);
  assign w_isOpImm32 = (w_opcode == OPC_OPIMM32);
  assign w_isLui     = (w_opcode == OPC_LUI);
  assign w_isAuipc   = (w_opcode == OPC_AUIPC);

  // Only register-register forms subtract; ADDI/ADDIW treat bit 30 as imm.
  assign w_isSub = (w_isOp | w_isOp32) & r_inst[30] & (w_f3 == 3'b000);
  assign w_isSra = r_inst[30] & (w_f3 == 3'b101);

  assign w_immI = XLEN'($signed(r_inst[31:20]));
  assign w_immU = XLEN'($signed({r_inst[31:12], 12'b0}));
  assign w_opB  = (w_isOp | w_isOp32) ? r_rs2 : w_immI;

  // 6-bit shift amount only exists on a 64-bit datapath.
  assign w_shamt = (XLEN == 64) ? w_opB[5:0] : {1'b0, w_opB[4:0]};

  // Full-width OP / OP-IMM result.
  always_comb begin
    w_full = '0;
    case (w_f3)
      3'b000:  w_full = w_isSub ? (r_rs1 - w_opB) : (r_rs1 + w_opB);
      3'b001:  w_full = r_rs1 << w_shamt;
      3'b010:  w_full = XLEN'($signed(r_rs1) < $signed(w_opB));
      3'b011:  w_full = XLEN'(r_rs1 < w_opB);
      3'b100:  w_full = r_rs1 ^ w_opB;
      3'b101:  w_full = w_isSra ? XLEN'($signed(r_rs1) >>> w_shamt)
                                : (r_rs1 >> w_shamt);
      3'b110:  w_full = r_rs1 | w_opB;
      default: w_full = r_rs1 & w_opB;
    endcase
  end

  // 32-bit W-form result, sign-extended from bit 31. Only ADD/SUB and the
  // shifts exist as W ops; the remaining func3 codes produce zero.
  assign w_a32 = r_rs1[31:0];
  assign w_b32 = w_opB[31:0];
  assign w_sh5 = w_opB[4:0];

  always_comb begin
    w_w32 = '0;
    case (w_f3)
      3'b000:  w_w32 = w_isSub ? (w_a32 - w_b32) : (w_a32 + w_b32);
      3'b001:  w_w32 = w_a32 << w_sh5;
      3'b101:  w_w32 = w_isSra ? 32'($signed(w_a32) >>> w_sh5)
                               : (w_a32 >> w_sh5);
      default: w_w32 = '0;
    endcase
  end

  assign w_wide = XLEN'($signed(w_w32));

  // Unknown opcodes still flow through the pipe with a zero result.
  always_comb begin
    w_result = '0;
    if (w_isOp | w_isOpImm) begin
      w_result = w_full;
    end else if (w_isOp32 | w_isOpImm32) begin
      w_result = (XLEN == 64) ? w_wide : '0;
    end else if (w_isLui) begin
      w_result = w_immU;
    end else if (w_isAuipc) begin
      w_result = r_pc + w_immU;
    end
  end

  assign w_stVal[0] = w_result;
  assign w_stSid[0] = r_sid0;
  assign w_stRd[0]  = r_inst[11:7];

  // Result-carrying stages. A stage only loads when its predecessor holds a
  // real op, so an emptied stage keeps its old payload harmlessly.
  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    logic [XLEN-1:0]  r_val;
    logic [SID_W-1:0] r_sid;
    logic [4:0]       r_rd;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_val <= '0;
        r_sid <= '0;
        r_rd  <= '0;
      end else if (!flush_i && w_adv[g] && r_valid[g-1]) begin
        r_val <= w_stVal[g-1];
        r_sid <= w_stSid[g-1];
        r_rd  <= w_stRd[g-1];
      end
    end

    assign w_stVal[g] = r_val;
    assign w_stSid[g] = r_sid;
    assign w_stRd[g]  = r_rd;
  end

  assign out_valid_o = r_valid[LAST];
  assign out_value_o = w_stVal[LAST];
  assign out_sid_o   = w_stSid[LAST];
  assign out_rd_o    = w_stRd[LAST];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe at XLEN=64, STAGES=2.
// Expected values are hand-computed constants for each vector.
module tb_alu_pipe;

  localparam int XLEN   = 64;
  localparam int SID_W  = 4;
  localparam int STAGES = 2;

  localparam logic [6:0] OP      = 7'b0110011;
  localparam logic [6:0] OPIMM   = 7'b0010011;
  localparam logic [6:0] OP32    = 7'b0111011;
  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] AUIPC   = 7'b0010111;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [SID_W-1:0] inSid = '0;
  logic [31:0]      inInst = '0;
  logic [XLEN-1:0]  inPc = '0;
  logic [XLEN-1:0]  inRs1 = '0;
  logic [XLEN-1:0]  inRs2 = '0;
  logic             outValid;
  logic             outReady = 1'b1;
  logic [SID_W-1:0] outSid;
  logic [4:0]       outRd;
  logic [XLEN-1:0]  outValue;
  logic             busy;

  int vectorCount = 0;
  int missCount   = 0;

  int               accepted;
  int               seen;
  logic             rdySample;
  logic [SID_W-1:0] gotSid [$];
  logic [XLEN-1:0]  gotVal [$];

  alu_pipe #(.XLEN(XLEN), .SID_W(SID_W), .STAGES(STAGES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_sid_i    (inSid),
    .in_inst_i   (inInst),
    .in_pc_i     (inPc),
    .in_rs1_i    (inRs1),
    .in_rs2_i    (inRs2),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_sid_o   (outSid),
    .out_rd_o    (outRd),
    .out_value_o (outValue),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkR(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] mkI(input logic [11:0] imm, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {imm, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] mkU(input logic [19:0] imm, input logic [4:0] rd,
                                      input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one op with out_ready high and checks ready, latency and result.
  // Called and returns just after a rising edge.
  task automatic applyStimulus(input string tag, input logic [31:0] inst,
                               input logic [63:0] pc, input logic [63:0] rs1,
                               input logic [63:0] rs2, input logic [3:0] sid,
                               input logic [63:0] expVal);
    logic [4:0] rdExp;
    rdExp   = inst[11:7];
    inInst  = inst;
    inPc    = pc;
    inRs1   = rs1;
    inRs2   = rs2;
    inSid   = sid;
    inValid = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".rdy"}, 64'(inReady), 64'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".lat"}, 64'(outValid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, ".vld"}, 64'(outValid), 64'd1);
    checkOutput({tag, ".val"}, outValue, expVal);
    checkOutput({tag, ".sid"}, 64'(outSid), 64'(sid));
    checkOutput({tag, ".rd"},  64'(outRd), 64'(rdExp));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst.vld",   64'(outValid), 64'd0);
    checkOutput("rst.busy",  64'(busy),     64'd0);
    checkOutput("rst.rdy",   64'(inReady),  64'd1);
    checkOutput("rst.sid",   64'(outSid),   64'd0);
    checkOutput("rst.rd",    64'(outRd),    64'd0);
    checkOutput("rst.value", outValue,      64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arithmetic / logic vectors
    applyStimulus("add",   mkR(7'h00, 3'b000, 5'd10, OP), 64'd0, 64'd5, 64'd7, 4'd3, 64'd12);
    applyStimulus("slt",   mkR(7'h00, 3'b010, 5'd11, OP), 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd4, 64'd1);
    applyStimulus("sltu",  mkR(7'h00, 3'b011, 5'd12, OP), 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd5, 64'd0);
    applyStimulus("sub",   mkR(7'h20, 3'b000, 5'd13, OP), 64'd0, 64'd3, 64'd5, 4'd6, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus("addi",  mkI(12'h400, 3'b000, 5'd14, OPIMM), 64'd0, 64'd10, 64'h999, 4'd7, 64'h40A);
    applyStimulus("and",   mkR(7'h00, 3'b111, 5'd15, OP), 64'd0, 64'hF0F0, 64'hFF00, 4'd8, 64'hF000);
    applyStimulus("srai",  mkI({6'b010000, 6'd60}, 3'b101, 5'd16, OPIMM), 64'd0,
                  64'h8000_0000_0000_0000, 64'd0, 4'd9, 64'hFFFF_FFFF_FFFF_FFF8);
    applyStimulus("addw",  mkR(7'h00, 3'b000, 5'd17, OP32), 64'd0, 64'h7FFF_FFFF, 64'd1, 4'd10,
                  64'hFFFF_FFFF_8000_0000);
    applyStimulus("sraw",  mkR(7'h20, 3'b101, 5'd18, OP32), 64'd0, 64'h8000_0000, 64'd4, 4'd11,
                  64'hFFFF_FFFF_F800_0000);
    applyStimulus("sltw",  mkR(7'h00, 3'b010, 5'd19, OP32), 64'd0, 64'd1, 64'd2, 4'd12, 64'd0);
    applyStimulus("auipc", mkU(20'h80000, 5'd20, AUIPC), 64'h1000, 64'd0, 64'd0, 4'd13,
                  64'hFFFF_FFFF_8000_1000);
    applyStimulus("lui",   mkU(20'h12345, 5'd21, LUI), 64'd0, 64'd0, 64'd0, 4'd14, 64'h1234_5000);
    applyStimulus("badop", 32'h0000_047F, 64'd0, 64'd9, 64'd9, 4'd15, 64'd0);

    // Backpressure: offer four ADDs (100+i) with the consumer stalled
    outReady = 1'b0;
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      inInst  = mkR(7'h00, 3'b000, 5'd1, OP);
      inSid   = SID_W'(8 + accepted);
      inRs1   = 64'(accepted);
      inRs2   = 64'd100;
      inValid = 1'b1;
      @(negedge clk);
      rdySample = inReady;
      @(posedge clk); #1;
      if (rdySample) accepted++;
    end
    inValid = 1'b0;
    checkOutput("bp.accepted", 64'(accepted), 64'(STAGES));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("bp.rdyLow",  64'(inReady),  64'd0);
      checkOutput("bp.holdVld", 64'(outValid), 64'd1);
      checkOutput("bp.holdSid", 64'(outSid),   64'd8);
      checkOutput("bp.holdVal", outValue,      64'd100);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    gotSid.delete();
    gotVal.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (outValid) begin
        gotSid.push_back(outSid);
        gotVal.push_back(outValue);
      end
    end
    @(posedge clk); #1;
    checkOutput("bp.count", 64'(gotSid.size()), 64'd2);
    checkOutput("bp.sid0", 64'((gotSid.size() > 0) ? gotSid[0] : 4'hF), 64'd8);
    checkOutput("bp.val0", (gotVal.size() > 0) ? gotVal[0] : 64'hDEAD, 64'd100);
    checkOutput("bp.sid1", 64'((gotSid.size() > 1) ? gotSid[1] : 4'hF), 64'd9);
    checkOutput("bp.val1", (gotVal.size() > 1) ? gotVal[1] : 64'hDEAD, 64'd101);

    // Flush with two ops in flight and a new op offered
    outReady = 1'b0;
    inInst   = mkR(7'h00, 3'b000, 5'd2, OP);
    inRs1    = 64'd1;
    inRs2    = 64'd1;
    inSid    = 4'd1;
    inValid  = 1'b1;
    @(posedge clk); #1;
    inSid    = 4'd2;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("fl.busyPre", 64'(busy), 64'd1);
    #1;
    flush    = 1'b1;
    inSid    = 4'd5;
    inRs1    = 64'd50;
    @(posedge clk); #1;
    flush    = 1'b0;
    inValid  = 1'b0;
    @(negedge clk);
    checkOutput("fl.busy", 64'(busy),     64'd0);
    checkOutput("fl.vld",  64'(outValid), 64'd0);
    checkOutput("fl.rdy",  64'(inReady),  64'd1);
    outReady = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (outValid) seen++;
    end
    @(posedge clk); #1;
    checkOutput("fl.noOut", 64'(seen), 64'd0);

    // Flush while the pipe is empty: ready is asserted but the op is dropped
    flush   = 1'b1;
    inValid = 1'b1;
    inSid   = 4'd6;
    @(negedge clk);
    checkOutput("fl2.rdy", 64'(inReady), 64'd1);
    @(posedge clk); #1;
    flush   = 1'b0;
    inValid = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (outValid || busy) seen++;
    end
    @(posedge clk); #1;
    checkOutput("fl2.noOut", 64'(seen), 64'd0);
    applyStimulus("postfl", mkR(7'h00, 3'b100, 5'd22, OP), 64'd0, 64'h0F, 64'hFF, 4'd7, 64'hF0);

    // Asynchronous reset while ops are in flight
    outReady = 1'b0;
    inInst   = mkR(7'h00, 3'b110, 5'd3, OP);
    inRs1    = 64'd4;
    inRs2    = 64'd1;
    inSid    = 4'd1;
    inValid  = 1'b1;
    @(posedge clk); #1;
    inSid    = 4'd2;
    @(posedge clk); #1;
    inValid  = 1'b0;
    @(negedge clk);
    checkOutput("ar.vldPre",  64'(outValid), 64'd1);
    checkOutput("ar.busyPre", 64'(busy),     64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ar.vld",  64'(outValid), 64'd0);
    checkOutput("ar.busy", 64'(busy),     64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("ar.rdy",    64'(inReady),  64'd1);
    checkOutput("ar.vldOut", 64'(outValid), 64'd0);
    checkOutput("ar.value",  outValue,      64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
